// File: rtl/div_round_pack_pkg.sv
// Single-precision constants, flag bit positions and the record types
// shared by the divider back end (sideband pipe and output FIFO).
package div_round_pack_pkg;

  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 255;
  localparam int FP_SIGN_W  = 1;
  localparam int FP_EXP_W   = 8;
  localparam int FP_MAN_W   = 23;
  localparam int FP_SIG_W   = FP_MAN_W + 1;
  localparam int FP_W       = FP_SIGN_W + FP_EXP_W + FP_MAN_W;

  localparam int FLAG_W     = 3;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_UNF   = 1;
  localparam int FLAG_INX   = 0;

  localparam int EXP_IN_W   = 10;

  // Per-operation data captured with start and carried alongside the divider
  typedef struct packed {
    logic                sign;
    logic [EXP_IN_W-1:0] exponent;
    logic                spec;
    logic [FP_W-1:0]     spec_val;
    logic [FLAG_W-1:0]   spec_flags;
  } side_t;

  // One finished result waiting in the output buffer
  typedef struct packed {
    logic [FP_W-1:0]   result;
    logic [FLAG_W-1:0] flags;
  } entry_t;

  // Assemble an IEEE-754 single from its three fields
  function automatic logic [FP_W-1:0] fp_pack(input logic sign,
                                              input logic [FP_EXP_W-1:0] e,
                                              input logic [FP_MAN_W-1:0] man);
    return {sign, e, man};
  endfunction

endpackage

// File: rtl/div_round_pack_round.sv
// Combinational normalize / round-to-nearest-even / pack stage for the
// divider quotient. The quotient carries its leading one at bit 24 or 23;
// anything below that is treated as a zero result. WIDTH must be >= 25.
module fp_round_rne
  import div_round_pack_pkg::*;
#(
  parameter int WIDTH = 26
) (
  input  logic [WIDTH-1:0]    quot,
  input  logic                sticky,
  input  logic                sign,
  input  logic [EXP_IN_W-1:0] exp_in,
  output logic [FP_W-1:0]     result,
  output logic [FLAG_W-1:0]   flags
);

  localparam logic signed [11:0] E_MAX = 12'(FP_EXP_MAX);

  logic [FP_SIG_W-1:0]  sig;
  logic                 guard;
  logic                 inc;
  logic                 inexact;
  logic [FP_SIG_W:0]    sum;
  logic signed [11:0]   exp_ext;
  logic signed [11:0]   e_norm;
  logic signed [11:0]   e_fin;
  logic                 unused_bits;

  assign exp_ext = $signed({{2{exp_in[EXP_IN_W-1]}}, exp_in});

  // Normalize: take 24 significand bits below the leading one; bit 0 becomes the guard
  always_comb begin
    sig    = quot[23:0];
    guard  = 1'b0;
    e_norm = exp_ext - 12'sd1;
    if (quot[24]) begin
      sig    = quot[24:1];
      guard  = quot[0];
      e_norm = exp_ext;
    end
  end

  // Round to nearest even; a carry out of 24 bits leaves 1.000 and bumps the exponent
  always_comb begin
    inc     = guard & (sticky | sig[0]);
    inexact = guard | sticky;
    sum     = {1'b0, sig} + {{FP_SIG_W{1'b0}}, inc};
    e_fin   = sum[FP_SIG_W] ? (e_norm + 12'sd1) : e_norm;
  end

  // Classify into zero / overflow / underflow / normal and pack the result
  always_comb begin
    result           = fp_pack(sign, e_fin[FP_EXP_W-1:0], sum[FP_MAN_W-1:0]);
    flags            = '0;
    flags[FLAG_INX]  = inexact;
    if (quot[24:23] == 2'b00) begin
      result = {sign, {(FP_W-1){1'b0}}};
      flags  = '0;
    end else if (e_fin >= E_MAX) begin
      result          = fp_pack(sign, {FP_EXP_W{1'b1}}, {FP_MAN_W{1'b0}});
      flags           = '0;
      flags[FLAG_OVF] = 1'b1;
      flags[FLAG_INX] = 1'b1;
    end else if (e_fin <= 12'sd0) begin
      result          = {sign, {(FP_W-1){1'b0}}};
      flags           = '0;
      flags[FLAG_UNF] = 1'b1;
      flags[FLAG_INX] = 1'b1;
    end
  end

  // Quotient top bit is always zero and sum[23] is the implied leading one
  assign unused_bits = ^{quot, sum[FP_SIG_W-1]};

endmodule

// File: rtl/div_round_pack.sv
// Back end of the fraction divider: carries each operation's sideband
// alongside the divider, rounds the quotient when it emerges, and buffers
// results in a small in-order FIFO. A credit counter covering in-flight
// tags plus buffered results guarantees the FIFO never overflows.
// STAGES must be >= 2.
module div_round_pack
  import div_round_pack_pkg::*;
#(
  parameter int WIDTH  = 26,
  parameter int STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                in_ready,
  input  logic                sign_in,
  input  logic [EXP_IN_W-1:0] exp_in,
  input  logic                spec_in,
  input  logic [FP_W-1:0]     spec_val,
  input  logic [FLAG_W-1:0]   spec_flags,
  input  logic [WIDTH-1:0]    quot,
  input  logic                sticky,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FP_W-1:0]     result,
  output logic [FLAG_W-1:0]   flags
);

  localparam int LAT   = STAGES - 1;
  localparam int DEPTH = LAT + 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              accept;
  logic              push;
  logic              pop;
  logic [LAT-1:0]    tag_pipe;
  side_t             side_pipe [LAT];
  side_t             side_head;
  entry_t            fifo_mem [DEPTH];
  entry_t            push_entry;
  entry_t            head_entry;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     fifo_cnt;
  logic [CW-1:0]     count;
  logic [FP_W-1:0]   rnd_result;
  logic [FLAG_W-1:0] rnd_flags;

  // Circular pointer advance that works for any DEPTH
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count < CW'(DEPTH));
  assign accept    = start & in_ready;
  assign push      = tag_pipe[LAT-1];
  assign side_head = side_pipe[LAT-1];
  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid & out_ready;

  // Tag pipe: a 1 at the last stage marks the cycle quot/sticky belong to an operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= accept;
      for (int i = 1; i < LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Sideband pipe: data only, qualified by the tag pipe so it needs no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      side_pipe[0] <= {sign_in, exp_in, spec_in, spec_val, spec_flags};
    end
    for (int i = 1; i < LAT; i++) begin
      side_pipe[i] <= side_pipe[i-1];
    end
  end

  fp_round_rne #(
    .WIDTH(WIDTH)
  ) u_round (
    .quot   (quot),
    .sticky (sticky),
    .sign   (side_head.sign),
    .exp_in (side_head.exponent),
    .result (rnd_result),
    .flags  (rnd_flags)
  );

  // Special results bypass the rounder and ignore the quotient entirely
  always_comb begin
    push_entry.result = rnd_result;
    push_entry.flags  = rnd_flags;
    if (side_head.spec) begin
      push_entry.result = side_head.spec_val;
      push_entry.flags  = side_head.spec_flags;
    end
  end

  // FIFO storage: written in the tagged cycle, never reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_entry;
    end
  end

  // FIFO pointers, occupancy and the credit count (in-flight tags + buffered entries)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      count    <= count + CW'(accept) - CW'(pop);
    end
  end

  // Head of the FIFO drives the outputs; zero while empty so reset shows all-zero
  always_comb begin
    head_entry = fifo_mem[rd_ptr];
    result     = '0;
    flags      = '0;
    if (out_valid) begin
      result = head_entry.result;
      flags  = head_entry.flags;
    end
  end

endmodule

// File: tb/tb_div_round_pack.sv
// Self-checking bench for div_round_pack at default parameters: directed
// vectors, randomized traffic with random back-pressure, a full stall and
// a mid-operation reset, all checked against an arithmetic reference model.
module tb_div_round_pack;

  localparam int WIDTH  = 26;
  localparam int STAGES = 2;
  localparam int DEPTH  = STAGES;

  typedef struct {
    bit          sign;
    logic [9:0]  ex;
    bit          spec;
    logic [31:0] sval;
    logic [2:0]  sflags;
    logic [25:0] quot;
    bit          sticky;
  } op_t;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_ready;
  logic              sign_in;
  logic [9:0]        exp_in;
  logic              spec_in;
  logic [31:0]       spec_val;
  logic [2:0]        spec_flags;
  logic [WIDTH-1:0]  quot;
  logic              sticky;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       result;
  logic [2:0]        flags;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  op_t  pend;
  bit   pend_valid = 1'b0;

  always #5 clk = ~clk;

  div_round_pack #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_ready   (in_ready),
    .sign_in    (sign_in),
    .exp_in     (exp_in),
    .spec_in    (spec_in),
    .spec_val   (spec_val),
    .spec_flags (spec_flags),
    .quot       (quot),
    .sticky     (sticky),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flags      (flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Reference: locate the leading one, round the tail to nearest even, classify
  function automatic exp_t ref_model(input op_t o);
    exp_t   r;
    longint q;
    longint keep;
    longint rem;
    int     s;
    int     e;
    bit     up;
    bit     inexact;
    if (o.spec) begin
      r.res = o.sval;
      r.flg = o.sflags;
      return r;
    end
    q = longint'(o.quot[24:0]);
    if (q < 'h800000) begin
      r.res = {o.sign, 31'h0};
      r.flg = 3'b000;
      return r;
    end
    s       = (q >= 'h1000000) ? 1 : 0;
    keep    = q >> s;
    rem     = q - (keep << s);
    e       = int'($signed(o.ex)) - 1 + s;
    up      = (rem == 1) && (o.sticky || keep[0]);
    inexact = (rem != 0) || o.sticky;
    keep    = keep + longint'(up);
    if (keep == 'h1000000) begin
      keep = 'h800000;
      e++;
    end
    if (e >= 255) begin
      r.res = {o.sign, 8'hFF, 23'h0};
      r.flg = 3'b101;
    end else if (e <= 0) begin
      r.res = {o.sign, 31'h0};
      r.flg = 3'b011;
    end else begin
      r.res = {o.sign, 8'(e), 23'(keep)};
      r.flg = {2'b00, inexact};
    end
    return r;
  endfunction

  function automatic op_t rand_op();
    op_t        o;
    logic [24:0] q;
    int         pick;
    o.sign   = 1'($urandom);
    o.ex     = 10'(int'($urandom_range(0, 275)) - 10);
    q        = 25'($urandom);
    pick     = int'($urandom_range(0, 9));
    if (pick == 0)      q[24:23] = 2'b00;
    else if (pick < 5)  q[24:23] = 2'b01;
    else if (pick == 9) q = 25'h1FFFFFF;
    else                q[24] = 1'b1;
    o.quot   = {1'b0, q};
    o.sticky = 1'($urandom);
    o.spec   = ($urandom_range(0, 7) == 0);
    o.sval   = $urandom;
    o.sflags = 3'($urandom);
    return o;
  endfunction

  function automatic op_t mk(input bit sg, input int ex, input logic [25:0] q, input bit st);
    op_t o;
    o        = rand_op();
    o.sign   = sg;
    o.ex     = 10'(ex);
    o.quot   = q;
    o.sticky = st;
    o.spec   = 1'b0;
    return o;
  endfunction

  // Compare outputs and ready against the model state for the current cycle
  task automatic checkOutput();
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check("in_ready", 32'(in_ready), 32'((exp_q.size() + int'(pend_valid)) < DEPTH));
    if (exp_q.size() != 0) begin
      check("result", result, exp_q[0].res);
      check("flags", 32'(flags), 32'(exp_q[0].flg));
    end
  endtask

  // One clock cycle: drive start/sideband for op, quot/sticky for the op in flight
  task automatic applyStimulus(input bit do_start, input op_t op);
    bit acc;
    bit popd;
    start      = do_start;
    sign_in    = op.sign;
    exp_in     = op.ex;
    spec_in    = op.spec;
    spec_val   = op.sval;
    spec_flags = op.sflags;
    if (pend_valid) begin
      quot   = pend.quot;
      sticky = pend.sticky;
    end else begin
      quot   = {1'b0, 25'($urandom)};
      sticky = 1'($urandom);
    end
    #1;
    checkOutput();
    acc  = do_start && ((exp_q.size() + int'(pend_valid)) < DEPTH);
    popd = (exp_q.size() != 0) && out_ready;
    @(posedge clk);
    if (popd) void'(exp_q.pop_front());
    if (pend_valid) exp_q.push_back(ref_model(pend));
    pend_valid = acc;
    if (acc) pend = op;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, rand_op());
  endtask

  initial begin
    op_t o;
    rst        = 1'b1;
    start      = 1'b0;
    sign_in    = 1'b0;
    exp_in     = '0;
    spec_in    = 1'b0;
    spec_val   = '0;
    spec_flags = '0;
    quot       = '0;
    sticky     = 1'b0;
    out_ready  = 1'b1;

    @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_result", result, 32'h0);
    check("rst_flags", 32'(flags), 32'd0);
    rst = 1'b0;

    $display("[TB] directed vectors");
    applyStimulus(1'b1, mk(0, 127, 26'h1000000, 0)); idle(3);
    applyStimulus(1'b1, mk(0, 127, 26'h0800000, 0)); idle(3);
    applyStimulus(1'b1, mk(0, 127, 26'h1000001, 0)); idle(3);
    applyStimulus(1'b1, mk(0, 127, 26'h1000003, 0)); idle(3);
    applyStimulus(1'b1, mk(0, 127, 26'h1FFFFFF, 1)); idle(3);
    applyStimulus(1'b1, mk(1, 254, 26'h1FFFFFF, 1)); idle(3);
    applyStimulus(1'b1, mk(0, 1, 26'h0800000, 0));   idle(3);
    applyStimulus(1'b1, mk(1, 100, 26'h0400000, 1)); idle(3);
    o        = mk(0, 127, 26'h1234567, 1);
    o.spec   = 1'b1;
    o.sval   = 32'h7FC00000;
    o.sflags = 3'b100;
    applyStimulus(1'b1, o); idle(3);

    $display("[TB] random traffic");
    for (int i = 0; i < 80; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      applyStimulus($urandom_range(0, 3) != 0, rand_op());
    end
    out_ready = 1'b1;
    idle(4);

    $display("[TB] stall with start every cycle");
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, rand_op());
    check("stall_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    idle(5);
    check("drained_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] reset mid-operation");
    out_ready = 1'b0;
    applyStimulus(1'b1, mk(0, 127, 26'h1000000, 0));
    applyStimulus(1'b1, mk(0, 128, 26'h1000000, 0));
    rst = 1'b1;
    #2;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_result", result, 32'h0);
    check("midrst_flags", 32'(flags), 32'd0);
    exp_q.delete();
    pend_valid = 1'b0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    idle(5);
    applyStimulus(1'b1, mk(0, 130, 26'h1800000, 0));
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
